processor: RTL and testbench

- Iterative arithmetic unit that computes the Gauss sum S(n) = 1 + 2 + … + n of an unsigned operand n.
- Serial datapath: one accumulate-and-decrement per clock, then a completion flag.
- Standalone compute block: free-running operand input, registered result and done outputs.

---
 rtl/processor.sv | 114 +++++++++++
 tb/tb_processor.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/processor.sv
// ----------------------------------------------------------------------------
// processor: iterative Gauss-sum unit, result = 1 + 2 + ... + n.
//
// The operand is latched once. The block then adds one term per clock,
// counting down from n to 1. When the last term has been added, it raises
// done and holds the finished sum.
//
// Ports:
//   clk     - system clock; all state changes on the rising edge
//   preset  - synchronous active-high reset; has priority over everything else
//   data    - unsigned operand n; sampled only in the LOAD state
//   result  - registered sum S(n) mod 2^width (or clamped, see below)
//   done    - registered; high while result holds a finished sum
//
// Optional feature macro: PROC_SATURATE_EN
//   Defined:   every accumulate clamps at all-ones if the add carries out.
//   Undefined: the sum wraps modulo 2^width.
// ----------------------------------------------------------------------------
module processor #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             preset,
    input  logic [width-1:0] data,
    output logic [width-1:0] result,
    output logic             done
);

    typedef enum logic [1:0] {
        StLoad = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [width-1:0]   acc_q, acc_d;
    logic [width-1:0]   cnt_q, cnt_d;
    logic [width-1:0]   n_q, n_d;
    logic [width-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic [width-1:0]   sum;

`ifdef PROC_SATURATE_EN
    logic [width:0] sum_full;
    assign sum_full = {1'b0, acc_q} + {1'b0, cnt_q};
    // A carry out clamps the sum. Once acc is all-ones, every later add
    // carries too (cnt >= 1), so the clamp holds until the end of the run.
    assign sum      = sum_full[width] ? '1 : sum_full[width-1:0];
`else
    assign sum      = acc_q + cnt_q;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        result_d = result_q;
        done_d   = done_q;
        case (state_q)
            StLoad: begin
                n_d      = data;
                cnt_d    = data;
                acc_d    = '0;
                result_d = '0;
                done_d   = 1'b0;
                state_d  = (data == '0) ? StDone : StRun;
            end
            StRun: begin
                acc_d = sum;
                cnt_d = cnt_q - 1'b1;
                // The last term publishes the sum on the same edge.
                if (cnt_q == {{(width-1){1'b0}}, 1'b1}) begin
                    result_d = sum;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                // For n=0 this is the edge that first raises done.
                // result keeps its value until LOAD clears it.
                if (data != n_q) begin
                    done_d  = 1'b0;
                    state_d = StLoad;
                end else begin
                    done_d  = 1'b1;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (preset) begin
            state_q  <= StLoad;
            acc_q    <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_processor.sv
// Directed bench for processor. Two instances are built: width=16 and width=4.
// Expected sums are pushed to a queue when an operand is applied, and popped
// when done is seen.
module tb_processor;

    logic        clk = 1'b0;
    logic        preset, preset4;
    logic [15:0] data, result;
    logic [3:0]  data4, result4;
    logic        done, done4;

    int unsigned exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    always #1 clk = ~clk;

    processor #(.width(16)) u_dut (
        .clk    (clk),
        .preset (preset),
        .data   (data),
        .result (result),
        .done   (done)
    );

    processor #(.width(4)) u_dut4 (
        .clk    (clk),
        .preset (preset4),
        .data   (data4),
        .result (result4),
        .done   (done4)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Step until done rises or the budget runs out. Check the edge count
    // when exp_edges >= 0, then compare result with the scoreboard head.
    task automatic wait_done(input string tag, input int start_edges, input int exp_edges,
                             input bit use4);
        int          edges;
        bit          seen;
        int unsigned exp_r;
        edges = start_edges;
        seen  = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step();
            edges++;
            seen = use4 ? done4 : done;
        end
        chk({tag, "_done"}, {31'd0, seen}, 32'd1);
        if (exp_edges >= 0) chk({tag, "_latency"}, edges, exp_edges);
        exp_r = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hdead_beef;
        chk({tag, "_result"}, use4 ? {28'd0, result4} : {16'd0, result}, exp_r);
    endtask

    initial begin
        preset  = 1'b1;
        preset4 = 1'b1;
        data    = 16'd10;
        data4   = 4'd5;
        @(negedge clk);
        step();
        chk("reset_result", {16'd0, result}, 32'd0);
        chk("reset_done",   {31'd0, done},   32'd0);
        chk("reset4_done",  {31'd0, done4},  32'd0);

        // Basic run, n=10.
        preset = 1'b0;
        exp_q.push_back(55);
        wait_done("n10", 0, 11, 1'b0);
        step(); step(); step();
        chk("hold_done",   {31'd0, done},   32'd1);
        chk("hold_result", {16'd0, result}, 32'd55);

        // Operand change while in DONE.
        data = 16'd5;
        exp_q.push_back(15);
        step();
        chk("chg_done_drop",   {31'd0, done},   32'd0);
        chk("chg_result_hold", {16'd0, result}, 32'd55);
        step();
        chk("chg_result_clr",  {16'd0, result}, 32'd0);
        wait_done("n5", 2, 7, 1'b0);

        // Zero operand right after reset.
        preset = 1'b1;
        data   = 16'd0;
        step();
        preset = 1'b0;
        exp_q.push_back(0);
        wait_done("n0", 0, 2, 1'b0);

        // Overflow boundary.
        data = 16'd362;
`ifdef PROC_SATURATE_EN
        exp_q.push_back(65535);
`else
        exp_q.push_back(167);
`endif
        wait_done("n362", 0, -1, 1'b0);
        data = 16'd361;
        exp_q.push_back(65341);
        wait_done("n361", 0, -1, 1'b0);

        // Operand change during RUN is ignored.
        preset = 1'b1;
        data   = 16'd10;
        step();
        preset = 1'b0;
        exp_q.push_back(55);
        step(); step(); step();
        data = 16'd7;
        wait_done("run_chg", 3, 11, 1'b0);

        // preset in the middle of RUN aborts, then recompute from current data.
        preset = 1'b1;
        data   = 16'd20;
        step();
        preset = 1'b0;
        step(); step(); step(); step();
        chk("mid_busy", {31'd0, done}, 32'd0);
        preset = 1'b1;
        data   = 16'd4;
        step();
        chk("abort_result", {16'd0, result}, 32'd0);
        chk("abort_done",   {31'd0, done},   32'd0);
        preset = 1'b0;
        exp_q.push_back(10);
        wait_done("n4", 0, 5, 1'b0);

        // Narrow instance: exact maximum, then wrap or clamp.
        preset4 = 1'b0;
        exp_q.push_back(15);
        wait_done("w4_n5", 0, 6, 1'b1);
        data4 = 4'd6;
`ifdef PROC_SATURATE_EN
        exp_q.push_back(15);
`else
        exp_q.push_back(5);
`endif
        wait_done("w4_n6", 0, 8, 1'b1);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
